// File: rtl/pipe_reg_chain.sv
// Elastic valid/ready pipeline of STAGES register slots carrying WIDTH-bit words.
// Latency: STAGES cycles from input accept to out_valid on an empty chain; 1 beat/cycle sustained.
// Backpressure: ready ripples back combinationally, empty slots collapse bubbles, full chain with out_ready=0 drops in_ready.
module pipe_reg_chain #(
    parameter int               WIDTH       = 32,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              OCC_W       = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    logic [STAGES-1:0] rdy;        // rdy[k]: the slot downstream of stage k can take a beat this cycle
    logic [STAGES-1:0] enter;      // a beat moves into stage k at this edge
    logic [STAGES-1:0] leave;      // the beat in stage k moves on at this edge
    logic [WIDTH-1:0]  src [STAGES];
    logic              stage0_free;
    logic              in_xfer;

    // Ready ripples from the consumer towards the input; any empty slot downstream opens the path.
    always_comb begin : ready_chain_c
        logic r;
        r           = out_ready;
        rdy         = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = r;
            r      = !vld_q[k] || r;
        end
        stage0_free = r;
    end

    assign in_ready = stage0_free && !clear && !reset;
    assign in_xfer  = in_valid && in_ready;

    // Per-stage move decisions; clear freezes inter-stage moves so data registers hold.
    always_comb begin : transfer_c
        enter           = '0;
        leave           = '0;
        src[0]          = in_data;
        enter[0]        = in_xfer;
        leave[STAGES-1] = vld_q[STAGES-1] && out_ready;
        for (int k = 0; k < STAGES - 1; k++) begin
            leave[k]     = vld_q[k] && rdy[k] && !clear;
            enter[k + 1] = leave[k];
            src[k + 1]   = data_q[k];
        end
    end

    // Next valid/data per stage; an arriving beat wins over a departing one, clear empties everything.
    always_comb begin : next_state_c
        vld_d  = vld_q;
        data_d = data_q;
        occ_d  = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (enter[k]) begin
                vld_d[k]  = 1'b1;
                data_d[k] = src[k];
            end else if (leave[k]) begin
                vld_d[k] = 1'b0;
            end
        end
        if (clear) begin
            vld_d = '0;
        end
        for (int k = 0; k < STAGES; k++) begin
            occ_d = occ_d + OCC_W'(vld_d[k]);
        end
    end

    // State registers with synchronous reset taking priority over clear and handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= RESET_VALUE;
            end
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a 2-stage and a 4-stage instance checked every cycle against a beat-position model.
// Latency: n/a (testbench).
// Backpressure: consumer ready and producer offers are randomized after the directed scenarios.
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr  [2];
    logic        iv   [2];
    logic [31:0] id   [2];
    logic        ordy [2];
    logic        ir   [2];
    logic        ov   [2];
    logic [31:0] od   [2];
    logic [1:0]  occ0;
    logic [2:0]  occ1;

    int n_vec = 0;
    int n_mis = 0;

    // Model: per instance, an ordered list of in-flight beats with their stage position.
    int          mcnt  [2];
    int          mpos  [2][8];
    logic [31:0] mdat  [2][8];
    logic [31:0] mlast [2];     // last word that reached the output stage
    bit          acc   [2];     // model says the offered beat was taken at the last edge

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(32), .STAGES(2), .RESET_VALUE(32'h0)) dut2 (
        .clk(clk), .reset(reset), .clear(clr[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(occ0)
    );

    pipe_reg_chain #(.WIDTH(32), .STAGES(4), .RESET_VALUE(32'h0)) dut4 (
        .clk(clk), .reset(reset), .clear(clr[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(occ1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] occ_of(input int i);
        return (i == 0) ? 32'(occ0) : 32'(occ1);
    endfunction

    // One clock of the reference: predict outputs from the beat list, compare, then advance the list.
    task automatic model_step(input int i, input bit do_chk);
        int s, n, k, tail_np, lim;
        int np [8];
        bit m_ov, pop, free, m_ir;
        s    = (i == 0) ? 2 : 4;
        n    = mcnt[i];
        m_ov = (n > 0) && (mpos[i][0] == s - 1);
        pop  = m_ov && ordy[i];
        // A beat advances one slot per cycle but never onto the slot the beat ahead ends up in.
        for (int j = 0; j < n; j++) begin
            if (j == 0 || (j == 1 && pop)) lim = s - 1;
            else                           lim = np[j - 1] - 1;
            np[j] = (mpos[i][j] + 1 < lim) ? mpos[i][j] + 1 : lim;
        end
        if (n == 0 || (n == 1 && pop)) begin
            free = 1'b1;
        end else begin
            tail_np = np[n - 1];
            free    = (tail_np > 0);
        end
        m_ir = !reset && !clr[i] && free;
        if (do_chk) begin
            check_eq($sformatf("in_ready[%0d]", i),  32'(ir[i]), 32'(m_ir));
            check_eq($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m_ov));
            check_eq($sformatf("out_data[%0d]", i),  od[i],      mlast[i]);
            check_eq($sformatf("occupancy[%0d]", i), occ_of(i),  32'(n));
        end
        acc[i] = 1'b0;
        if (reset) begin
            mcnt[i]  = 0;
            mlast[i] = 32'h0;
        end else if (clr[i]) begin
            mcnt[i] = 0;
        end else begin
            k = 0;
            for (int j = (pop ? 1 : 0); j < n; j++) begin
                if (np[j] == s - 1 && mpos[i][j] != s - 1) mlast[i] = mdat[i][j];
                mpos[i][k] = np[j];
                mdat[i][k] = mdat[i][j];
                k++;
            end
            if (iv[i] && m_ir) begin
                mpos[i][k] = 0;
                mdat[i][k] = id[i];
                k++;
                acc[i] = 1'b1;
            end
            mcnt[i] = k;
        end
    endtask

    task automatic cycle(input bit do_chk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) model_step(i, do_chk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clr[i]   = 1'b0;
            iv[i]    = 1'b1;
            id[i]    = 32'hDEADBEEF;
            ordy[i]  = 1'b0;
            mcnt[i]  = 0;
            mlast[i] = 32'h0;
            acc[i]   = 1'b0;
        end
        // Reset held two cycles with a beat offered; first edge only establishes state.
        cycle(1'b0);
        cycle(1'b1);
        reset = 1'b0;
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        check_eq("rst_out_data", od[0], 32'h0);
        check_eq("rst_out_valid", 32'(ov[0]), 32'h0);
        check_eq("rst_occupancy", occ_of(1), 32'h0);

        // Streaming on the 2-stage chain: beat 1 shows one edge after its accept edge.
        ordy[0] = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            iv[0] = 1'b1;
            id[0] = 32'(b);
            cycle(1'b1);
            if (b == 1) check_eq("stream_lat_lo", 32'(ov[0]), 32'h0);
            if (b == 2) check_eq("stream_first", od[0], 32'h1);
        end
        iv[0] = 1'b0;
        repeat (3) cycle(1'b1);

        // Backpressure: A and B fill the chain, C is held until the consumer is ready.
        ordy[0] = 1'b0;
        iv[0] = 1'b1; id[0] = 32'hA; cycle(1'b1);
        id[0] = 32'hB; cycle(1'b1);
        id[0] = 32'hC; cycle(1'b1);
        check_eq("bp_full_ir", 32'(ir[0]), 32'h0);
        check_eq("bp_full_occ", occ_of(0), 32'h2);
        check_eq("bp_head", od[0], 32'hA);
        ordy[0] = 1'b1;
        cycle(1'b1);
        iv[0] = 1'b0;
        repeat (4) cycle(1'b1);

        // Bubble collapse on the 4-stage chain with the consumer stalled.
        ordy[1] = 1'b0;
        iv[1] = 1'b1; id[1] = 32'h55; cycle(1'b1);
        iv[1] = 1'b0;
        repeat (3) cycle(1'b1);
        check_eq("bub_valid", 32'(ov[1]), 32'h1);
        check_eq("bub_data", od[1], 32'h55);
        check_eq("bub_occ1", occ_of(1), 32'h1);
        iv[1] = 1'b1; id[1] = 32'h66; cycle(1'b1);
        iv[1] = 1'b0;
        repeat (3) cycle(1'b1);
        check_eq("bub_occ2", occ_of(1), 32'h2);

        // Clear with three beats held: head leaves, offered beat is refused then taken next cycle.
        iv[1] = 1'b1; id[1] = 32'h77; cycle(1'b1);
        iv[1] = 1'b0;
        repeat (2) cycle(1'b1);
        check_eq("clr_occ3", occ_of(1), 32'h3);
        ordy[1] = 1'b1;
        clr[1]  = 1'b1;
        iv[1]   = 1'b1;
        id[1]   = 32'h88;
        cycle(1'b1);
        clr[1] = 1'b0;
        check_eq("clr_valid", 32'(ov[1]), 32'h0);
        check_eq("clr_occ0", occ_of(1), 32'h0);
        cycle(1'b1);
        check_eq("clr_accept_occ", occ_of(1), 32'h1);
        iv[1] = 1'b0;
        repeat (5) cycle(1'b1);

        // Reset while two beats are held; nothing may reappear afterwards.
        ordy[0] = 1'b0;
        iv[0] = 1'b1; id[0] = 32'h1234; cycle(1'b1);
        id[0] = 32'h5678; cycle(1'b1);
        iv[0] = 1'b0;
        check_eq("mid_occ2", occ_of(0), 32'h2);
        reset = 1'b1;
        cycle(1'b1);
        reset = 1'b0;
        check_eq("mid_rst_occ", occ_of(0), 32'h0);
        check_eq("mid_rst_data", od[0], 32'h0);
        ordy[0] = 1'b1;
        repeat (4) cycle(1'b1);

        // Randomized traffic on both chains; producers hold a refused beat stable.
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!iv[i] || acc[i]) begin
                    iv[i] = ($urandom_range(0, 3) != 0);
                    id[i] = $urandom;
                end
                ordy[i] = ($urandom_range(0, 2) != 0);
                clr[i]  = ($urandom_range(0, 39) == 0);
            end
            reset = ($urandom_range(0, 299) == 0);
            cycle(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
